// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Load/store front end between the core LSU and a word-wide, byte-enabled
//   data RAM with one cycle of read latency. Sized requests (byte/half/word)
//   become aligned word accesses with byte enables and replicated write data.
//   Read data is aligned and sign/zero-extended. Misaligned, illegal-size and
//   out-of-window requests are answered with an error and never reach the RAM.
//   Each response is held under valid/ready backpressure.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             LSU request handshake
//   req_addr, req_we, req_size,     byte address, store flag, size code
//   req_unsigned, req_wdata         (00 byte, 01 half, 10 word, 11 illegal),
//                                   load zero-extend flag, right-justified data
//   rsp_valid/rsp_ready             LSU response handshake
//   rsp_rdata, rsp_err              extended load data (0 for stores/errors), error
//   mem_req, mem_addr, mem_we,      RAM access strobe, word-aligned byte address,
//   mem_be, mem_wdata               write enable, byte enables, write data
//   mem_rdata                       RAM read data, valid the cycle after mem_req
module data_mem_ctrl #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  // Window size held in 33 bits so a 4 GiB window still compares correctly.
  localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH) * 33'd4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e      state_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;

  logic        accept;
  logic        req_err;
  logic        out_of_range;
  logic [31:0] rel_addr;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  // Addresses below BASE_ADDR wrap to large offsets and fall out of range.
  assign rel_addr     = req_addr - BASE_ADDR;
  assign out_of_range = ({1'b0, rel_addr} >= WINDOW_BYTES);

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    req_err = req_err | out_of_range;
  end

  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  assign mem_req   = accept && !req_err;
  assign mem_we    = mem_req && req_we;
  assign mem_addr  = mem_req ? {req_addr[31:2], 2'b00} : '0;

  always_comb begin
    mem_be    = '0;
    mem_wdata = '0;
    if (mem_req) begin
      case (req_size)
        2'b00: begin
          mem_be    = 4'b0001 << req_addr[1:0];
          mem_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          mem_be    = req_addr[1] ? 4'b1100 : 4'b0011;
          mem_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          mem_be    = 4'b1111;
          mem_wdata = req_wdata;
        end
      endcase
      if (!req_we) begin
        mem_be = 4'b1111;
      end
    end
  end

  // Read data arrives in ACCESS, so alignment uses the captured fields.
  always_comb begin
    ld_shift = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'h0, ld_shift[7:0]}
                               : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = uns_q ? {16'h0, ld_shift[15:0]}
                               : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // An accept can only occur in IDLE or in RESP during the response
  // handshake, so it is handled once ahead of the per-state behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= '0;
      off_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (accept) begin
      if (req_err) begin
        state_q     <= RESP;
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= 1'b1;
        rsp_rdata_q <= '0;
      end else begin
        state_q     <= ACCESS;
        rsp_valid_q <= 1'b0;
        we_q        <= req_we;
        uns_q       <= req_unsigned;
        size_q      <= req_size;
        off_q       <= req_addr[1:0];
      end
    end else begin
      case (state_q)
        IDLE: state_q <= IDLE;
        ACCESS: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= we_q ? '0 : ld_data;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
//   Directed and randomized load/store traffic against data_mem_ctrl with a
//   1-cycle RAM attached. Expected responses come from a byte-array model of
//   memory and the sizing/alignment/window rules.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0100;
  localparam int unsigned NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  data_mem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM attached to the controller: word array, byte enables, 1-cycle read.
  logic [31:0] ram [DEPTH];
  logic [31:0] ram_off;
  assign ram_off = mem_addr - BASE;

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) ram[ram_off[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
      mem_rdata <= ram[ram_off[7:2]];
    end
  end

  // Reference memory, one entry per byte of the window.
  logic [7:0] ref_mem [NBYTES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic f_err(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] rel;
    rel = a - BASE;
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && (a % 2) != 0) return 1'b1;
    if (s == 2'd2 && (a % 4) != 0) return 1'b1;
    return rel >= 32'(NBYTES);
  endfunction

  function automatic logic [3:0] f_be(input logic we, input logic [1:0] s, input logic [31:0] a);
    if (!we) return 4'hF;
    case (s)
      2'd0:    return 4'(1 << (a % 4));
      2'd1:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] f_wd(input logic [1:0] s, input logic [31:0] w);
    case (s)
      2'd0:    return (w & 32'hFF) * 32'h0101_0101;
      2'd1:    return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [31:0] rel;
    logic [31:0] v;
    int n;
    rel = a - BASE;
    n   = nbytes(s);
    v   = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[rel + 32'(i)]) << (8 * i));
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
    logic [31:0] rel;
    rel = a - BASE;
    for (int i = 0; i < nbytes(s); i++) ref_mem[rel + 32'(i)] = 8'((w >> (8 * i)) & 32'hFF);
  endtask

  // Present a request, check the RAM-side strobes in the accept cycle, and
  // step past the accepting edge.
  task automatic send(input logic we, input logic [1:0] s, input logic u,
                      input logic [31:0] a, input logic [31:0] w,
                      output logic e_err, output logic [31:0] e_rd);
    int k;
    req_valid = 1'b1; req_we = we; req_size = s; req_unsigned = u;
    req_addr = a; req_wdata = w;
    k = 0;
    while (req_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1; k++;
    end
    #1;
    chk("req_ready_accept", 32'(req_ready), 32'd1);
    e_err = f_err(a, s);
    e_rd  = (e_err || we) ? 32'h0 : f_load(a, s, u);
    chk("mem_req", 32'(mem_req), 32'(!e_err));
    if (!e_err) begin
      chk("mem_addr", mem_addr, a & ~32'h3);
      chk("mem_we", 32'(mem_we), 32'(we));
      chk("mem_be", 32'(mem_be), 32'(f_be(we, s, a)));
      if (we) chk("mem_wdata", mem_wdata, f_wd(s, w));
    end else begin
      chk("mem_be_idle", 32'(mem_be), 32'h0);
      chk("mem_wdata_idle", mem_wdata, 32'h0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_we = 1'($urandom);
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
    if (!e_err && we) m_store(a, s, w);
  endtask

  // Called one cycle after accept: checks response timing and contents.
  task automatic collect_wait(input logic e_err, input logic [31:0] e_rd);
    if (e_err) begin
      chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("err_rsp_err", 32'(rsp_err), 32'd1);
      chk("err_rsp_rdata", rsp_rdata, 32'h0);
    end else begin
      chk("rsp_valid_early", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_err", 32'(rsp_err), 32'd0);
      chk("rsp_rdata", rsp_rdata, e_rd);
    end
  endtask

  task automatic collect_hs(input logic e_err, input logic [31:0] e_rd, input int hold);
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, e_rd);
      chk("hold_err", 32'(rsp_err), 32'(e_err));
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("after_hs_valid", 32'(rsp_valid), 32'd0);
  endtask

  task automatic txn(input logic we, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] w, input int hold,
                     output logic [31:0] got);
    logic e_err;
    logic [31:0] e_rd;
    send(we, s, u, a, w, e_err, e_rd);
    collect_wait(e_err, e_rd);
    got = rsp_rdata;
    collect_hs(e_err, e_rd, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic        e_err_m;
  logic [31:0] e_rd_m;
  logic [31:0] got;
  logic [31:0] held;

  initial begin
    for (int wi = 0; wi < int'(DEPTH); wi++) begin
      logic [31:0] word;
      word = $urandom;
      ram[wi] = word;
      for (int bi = 0; bi < 4; bi++) ref_mem[4*wi + bi] = word[8*bi +: 8];
    end

    // Reset state
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: word store then word load
    txn(1'b1, 2'd2, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 0, got);
    txn(1'b0, 2'd2, 1'b0, BASE + 32'h10, 32'h0, 0, got);
    chk("t1_word_load", got, 32'hDEAD_BEEF);

    // 2: byte store, signed and unsigned byte loads
    txn(1'b1, 2'd0, 1'b0, BASE + 32'h13, 32'h1234_56A5, 1, got);
    txn(1'b0, 2'd0, 1'b0, BASE + 32'h13, 32'h0, 0, got);
    chk("t2_byte_signed", got, 32'hFFFF_FFA5);
    txn(1'b0, 2'd0, 1'b1, BASE + 32'h13, 32'h0, 0, got);
    chk("t2_byte_unsigned", got, 32'h0000_00A5);
    txn(1'b1, 2'd1, 1'b0, BASE + 32'h22, 32'h0000_8001, 0, got);
    txn(1'b0, 2'd1, 1'b0, BASE + 32'h22, 32'h0, 0, got);
    txn(1'b0, 2'd1, 1'b1, BASE + 32'h22, 32'h0, 0, got);

    // 3, 4: misaligned, out of window, below base, illegal size
    txn(1'b0, 2'd1, 1'b0, BASE + 32'h21, 32'h0, 0, got);
    txn(1'b0, 2'd2, 1'b0, BASE + 32'h22, 32'h0, 2, got);
    txn(1'b0, 2'd2, 1'b0, BASE + 32'(NBYTES), 32'h0, 0, got);
    txn(1'b1, 2'd0, 1'b0, BASE - 32'h1, 32'h55, 0, got);
    txn(1'b0, 2'd3, 1'b0, BASE + 32'h4, 32'h0, 0, got);
    txn(1'b0, 2'd2, 1'b0, BASE + 32'(NBYTES) - 32'h4, 32'h0, 0, got);

    // 5: backpressure with a pending request, then handshake + accept together
    send(1'b0, 2'd2, 1'b0, BASE + 32'h10, 32'h0, e_err_m, e_rd_m);
    collect_wait(e_err_m, e_rd_m);
    held = rsp_rdata;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = BASE + 32'h40;
    req_wdata = 32'h1234_5678; req_unsigned = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t5_valid", 32'(rsp_valid), 32'd1);
      chk("t5_rdata", rsp_rdata, e_rd_m);
      chk("t5_stable", rsp_rdata, held);
      chk("t5_req_ready", 32'(req_ready), 32'd0);
      chk("t5_mem_req", 32'(mem_req), 32'd0);
    end
    rsp_ready = 1'b1;
    send(1'b1, 2'd2, 1'b0, BASE + 32'h40, 32'h1234_5678, e_err_m, e_rd_m);
    rsp_ready = 1'b0;
    collect_wait(e_err_m, e_rd_m);
    collect_hs(e_err_m, e_rd_m, 0);
    txn(1'b0, 2'd2, 1'b0, BASE + 32'h40, 32'h0, 0, got);

    // 6: reset during ACCESS; the issued write still lands
    send(1'b1, 2'd2, 1'b0, BASE + 32'h80, 32'hCAFE_F00D, e_err_m, e_rd_m);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_in_reset", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("t6_req_ready", 32'(req_ready), 32'd1);
    chk("t6_rsp_err", 32'(rsp_err), 32'd0);
    chk("t6_rsp_rdata", rsp_rdata, 32'h0);
    @(posedge clk); #1;
    chk("t6_no_stale_rsp", 32'(rsp_valid), 32'd0);
    txn(1'b0, 2'd2, 1'b0, BASE + 32'h80, 32'h0, 0, got);
    chk("t6_write_landed", got, 32'hCAFE_F00D);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      int r;
      logic [1:0]  s;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      s = 2'($urandom_range(0, 3));
      if (r == 0) a = BASE + 32'(NBYTES) + 32'($urandom_range(0, 31));
      else if (r == 1) a = BASE - 32'h1 - 32'($urandom_range(0, 31));
      else begin
        a = BASE + 32'($urandom_range(0, NBYTES - 1));
        if (r > 3 && s == 2'd1) a[0] = 1'b0;
        if (r > 3 && s == 2'd2) a[1:0] = 2'b00;
      end
      txn(1'($urandom), s, 1'($urandom), a, $urandom, int'($urandom_range(0, 2)), got);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
